retire_store_buffer: RTL and testbench
======================================

// Module: retire_store_buffer
// PURPOSE
//  Receiver side of the retire-stage store interface (store2Dmem_command/size/addr/data).
//  Buffers committed stores in a FIFO and drains them to the Dmem port in retire order,
//  yielding to loads. Sits between stage_ir and the Dmem arbiter.
//  Committed stores are architectural, so no squash/flush input exists.
// PARAMETERS
//  DEPTH     8   number of buffered committed stores (power of 2, >=2)
// PORTS
//  clock               in   1              system clock
//  reset_n             in   1              asynchronous reset, active-low
//  st_command          in   2              BUS_STORE = enqueue; BUS_NONE = idle; other codes ignored
//  st_size             in   MEM_SIZE       store size from retire
//  st_addr             in   XLEN           store byte address
//  st_data             in   XLEN           store data (rs2 value)
//  sb_full             out  1              count==DEPTH; retire must not retire a store
//  sb_empty            out  1              count==0
//  sb_count            out  $clog2(DEPTH+1) occupancy
//  sb_overflow         out  1              sticky: a store arrived while full and was dropped
//  dmem_port_busy      in   1              load owns the Dmem port this cycle
//  proc2Dmem_command   out  2              BUS_STORE while draining, else BUS_NONE
//  proc2Dmem_size      out  MEM_SIZE       head entry size
//  proc2Dmem_addr      out  XLEN           head entry address
//  proc2Dmem_data      out  XLEN           head entry data
//  Dmem2proc_response  in   4              nonzero tag = store accepted this cycle
//  ld_addr             in   XLEN           [SB_LOAD_FWD_EN only] load lookup address
//  ld_size             in   MEM_SIZE       [SB_LOAD_FWD_EN only] load lookup size
//  fwd_hit             out  1              [SB_LOAD_FWD_EN only] exact match found
//  fwd_data            out  XLEN           [SB_LOAD_FWD_EN only] data of youngest match
//  fwd_stall           out  1              [SB_LOAD_FWD_EN only] partial overlap; load must wait
// BEHAVIOUR
//  Reset (async, reset_n=0): head=tail=0, count=0, FSM=IDLE, sb_overflow=0, all entries invalid.
//   Outputs: sb_empty=1, sb_full=0, proc2Dmem_command=BUS_NONE.
//   Reset mid-drain discards buffered stores; the memory side sees the command drop the same cycle.
//  Enqueue: st_command==BUS_STORE && !sb_full -> write {size,addr,data} at tail; tail++ mod DEPTH.
//   Visible at head no earlier than the next cycle.
//  Enqueue while full: store is dropped and sb_overflow is set. It stays set until reset.
//   A pop in the same cycle does NOT free a slot for the arriving store; full is evaluated on registered count.
//  FSM IDLE: if count!=0 go to DRAIN next cycle. Command is BUS_NONE.
//  FSM DRAIN: if dmem_port_busy, drive BUS_NONE and hold.
//   Else drive BUS_STORE with head fields, combinationally.
//   If Dmem2proc_response!=0 the same cycle: pop (head++, count--).
//   After a pop: stay in DRAIN if count after update !=0, else go to IDLE. No pop means retry next cycle.
//  Minimum latency: enqueue cycle N -> BUS_STORE issued at N+2 from an empty buffer.
//   Throughput is 1 store/cycle while accepted.
//  Simultaneous enqueue and pop: count unchanged. Pointers wrap at DEPTH.
//  Ordering: strict FIFO. Stores reach memory in retire order.
// CONFIGURATION
//  SB_LOAD_FWD_EN defined: ld_* / fwd_* ports exist.
//   Combinational search of valid entries, youngest first.
//   fwd_hit=1 when an entry has equal addr and equal size; fwd_data is that entry's data.
//   fwd_stall=1 when the youngest entry in the same 8-byte block is not an exact match.
//   fwd_hit and fwd_stall are never both 1.
//  SB_LOAD_FWD_EN undefined: those ports and the search logic are absent.
//   Loads must wait for sb_empty.
// STRUCTURE
//  sys_defs.svh gets:
//   typedef struct packed {MEM_SIZE size; logic [XLEN-1:0] addr, data;} SB_ENTRY;
//   typedef enum logic {SB_IDLE, SB_DRAIN} SB_STATE;
//  One sub-module: sb_entry_fifo (DEPTH x SB_ENTRY circular buffer with head/tail/count).
//   The FSM and forwarding search live in the top module.
// TESTING
//  1. Reset, one store (addr 0x100, data 0xDEAD_BEEF, WORD), response=1 every cycle
//     -> BUS_STORE at cycle +2, then sb_empty=1.
//  2. Fill 8 stores with the response held at 0 -> sb_full=1.
//     A 9th store sets sb_overflow=1; the 9th is never issued.
//  3. 3 stores queued, dmem_port_busy=1 for 4 cycles -> command BUS_NONE throughout.
//     Stores are then issued in order 0,1,2.
//  4. Full buffer, pop and enqueue in the same cycle -> new store dropped, sb_overflow=1, count=7.
//  5. FWD_EN: stores 0x200 WORD 0x11 then 0x200 WORD 0x22; load 0x200 WORD -> fwd_hit=1, fwd_data=0x22.
//     Load 0x202 HALF -> fwd_stall=1.
//  6. Assert reset_n=0 mid-drain with 4 queued -> command BUS_NONE immediately, count=0, sb_overflow=0.

Source files
------------

// File: rtl/retire_store_buffer_pkg.sv
// Shared types for the retire store buffer: bus command codes, access sizes, entry layout, FSM states.
package retire_store_buffer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef struct packed {
    MEM_SIZE         size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } SB_ENTRY;

  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_DRAIN = 1'b1
  } SB_STATE;

endpackage

// File: rtl/retire_store_buffer_sb_entry_fifo.sv
// DEPTH x SB_ENTRY circular buffer; head entry visible the cycle after its push.
// Caller must not push when full nor pop when empty; entries are exported when SB_LOAD_FWD_EN is defined.
module retire_store_buffer_sb_entry_fifo
  import retire_store_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  SB_ENTRY          push_entry,
  input  logic             pop,
  output SB_ENTRY          head_entry,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef SB_LOAD_FWD_EN
  ,
  output SB_ENTRY          entries [DEPTH],
  output logic [PTR_W-1:0] head
`endif
);

  SB_ENTRY          mem [DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone says which slots are live.
  always_ff @(posedge clock) begin
    if (push) mem[tail_ptr] <= push_entry;
  end

  assign head_entry = mem[head_ptr];
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);

`ifdef SB_LOAD_FWD_EN
  assign entries = mem;
  assign head    = head_ptr;
`endif

endmodule

// File: rtl/retire_store_buffer.sv
// Retire-side committed-store buffer draining in order to the Dmem port, yielding to loads.
// Latency: enqueue at N -> BUS_STORE at N+2 when empty; drain holds while dmem_port_busy or no response.
// Optional macro SB_LOAD_FWD_EN adds the youngest-first load forwarding search.
module retire_store_buffer
  import retire_store_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       st_command,
  input  MEM_SIZE          st_size,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic             sb_full,
  output logic             sb_empty,
  output logic [CNT_W-1:0] sb_count,
  output logic             sb_overflow,
  input  logic             dmem_port_busy,
  output logic [1:0]       proc2Dmem_command,
  output MEM_SIZE          proc2Dmem_size,
  output logic [XLEN-1:0]  proc2Dmem_addr,
  output logic [XLEN-1:0]  proc2Dmem_data,
  input  logic [3:0]       Dmem2proc_response
`ifdef SB_LOAD_FWD_EN
  ,
  input  logic [XLEN-1:0]  ld_addr,
  input  MEM_SIZE          ld_size,
  output logic             fwd_hit,
  output logic [XLEN-1:0]  fwd_data,
  output logic             fwd_stall
`endif
);

  SB_STATE state, state_nxt;
  SB_ENTRY head_entry;
  logic    push, pop, st_req;

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign st_req = (st_command == BUS_STORE);
  assign push   = st_req && !sb_full;

`ifdef SB_LOAD_FWD_EN
  SB_ENTRY          entries [DEPTH];
  logic [PTR_W-1:0] head;
  SB_ENTRY          probe;
`endif

  retire_store_buffer_sb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry ('{size: st_size, addr: st_addr, data: st_data}),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (sb_count),
    .full       (sb_full),
    .empty      (sb_empty)
`ifdef SB_LOAD_FWD_EN
    ,
    .entries    (entries),
    .head       (head)
`endif
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SB_IDLE;
      sb_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (st_req && sb_full) sb_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt         = state;
    proc2Dmem_command = BUS_NONE;
    pop               = 1'b0;
    case (state)
      SB_IDLE: if (!sb_empty) state_nxt = SB_DRAIN;
      SB_DRAIN: begin
        if (sb_empty) begin
          state_nxt = SB_IDLE;
        end else if (!dmem_port_busy) begin
          proc2Dmem_command = BUS_STORE;
          pop               = (Dmem2proc_response != 4'h0);
          if (pop && !push && sb_count == CNT_W'(1)) state_nxt = SB_IDLE;
        end
      end
      default: state_nxt = SB_IDLE;
    endcase
  end

  assign proc2Dmem_size = head_entry.size;
  assign proc2Dmem_addr = head_entry.addr;
  assign proc2Dmem_data = head_entry.data;

`ifdef SB_LOAD_FWD_EN
  // Walk oldest to youngest so the youngest same-block entry has the final say.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    probe     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      probe = entries[head + PTR_W'(i)];
      if (CNT_W'(i) < sb_count && probe.addr[XLEN-1:3] == ld_addr[XLEN-1:3]) begin
        fwd_hit   = (probe.addr == ld_addr) && (probe.size == ld_size);
        fwd_stall = !fwd_hit;
        fwd_data  = fwd_hit ? probe.data : '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_retire_store_buffer.sv
// Bench for retire_store_buffer: directed vector tables, hand sequences, and randomized traffic vs a queue model.
module tb_retire_store_buffer;
  import retire_store_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset_n;
  logic [1:0]       st_command;
  MEM_SIZE          st_size;
  logic [31:0]      st_addr, st_data;
  logic             sb_full, sb_empty, sb_overflow;
  logic [CNT_W-1:0] sb_count;
  logic             dmem_port_busy;
  logic [1:0]       proc2Dmem_command;
  MEM_SIZE          proc2Dmem_size;
  logic [31:0]      proc2Dmem_addr, proc2Dmem_data;
  logic [3:0]       Dmem2proc_response;
`ifdef SB_LOAD_FWD_EN
  logic [31:0]      ld_addr;
  MEM_SIZE          ld_size;
  logic             fwd_hit, fwd_stall;
  logic [31:0]      fwd_data;
  logic             smp_hit, smp_stall;
  logic [31:0]      smp_fdata;
`endif

  always #5 clock = ~clock;

  retire_store_buffer #(.DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .st_command         (st_command),
    .st_size            (st_size),
    .st_addr            (st_addr),
    .st_data            (st_data),
    .sb_full            (sb_full),
    .sb_empty           (sb_empty),
    .sb_count           (sb_count),
    .sb_overflow        (sb_overflow),
    .dmem_port_busy     (dmem_port_busy),
    .proc2Dmem_command  (proc2Dmem_command),
    .proc2Dmem_size     (proc2Dmem_size),
    .proc2Dmem_addr     (proc2Dmem_addr),
    .proc2Dmem_data     (proc2Dmem_data),
    .Dmem2proc_response (Dmem2proc_response)
`ifdef SB_LOAD_FWD_EN
    ,
    .ld_addr            (ld_addr),
    .ld_size            (ld_size),
    .fwd_hit            (fwd_hit),
    .fwd_data           (fwd_data),
    .fwd_stall          (fwd_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: retire-ordered queue plus "draining" flag and sticky overflow.
  SB_ENTRY     mq[$];
  bit          m_active;
  bit          m_ovf;
  logic [31:0] issued[$];

  logic [1:0]       smp_cmd;
  logic [31:0]      smp_addr;
  logic [CNT_W-1:0] smp_count;
  logic             smp_empty, smp_full, smp_ovf;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    MEM_SIZE     size;
    logic        busy;
    logic [3:0]  resp;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    int          e_count;
    logic        e_empty;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One clock: drive inputs, check outputs against model at negedge, advance model at posedge.
  task automatic step(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] d,
                      input MEM_SIZE sz, input logic busy, input logic [3:0] resp);
    bit exp_store;
    int n_before;
    st_command = cmd; st_addr = a; st_data = d; st_size = sz;
    dmem_port_busy = busy; Dmem2proc_response = resp;
    @(negedge clock);
    exp_store = m_active && !busy && (mq.size() != 0);
    smp_cmd = proc2Dmem_command; smp_addr = proc2Dmem_addr; smp_count = sb_count;
    smp_empty = sb_empty; smp_full = sb_full; smp_ovf = sb_overflow;
    chk("cmd", 64'(proc2Dmem_command), 64'(exp_store ? BUS_STORE : BUS_NONE));
    if (exp_store) begin
      chk("head_addr", 64'(proc2Dmem_addr), 64'(mq[0].addr));
      chk("head_data", 64'(proc2Dmem_data), 64'(mq[0].data));
      chk("head_size", 64'(proc2Dmem_size), 64'(mq[0].size));
    end
    chk("count", 64'(sb_count), 64'(mq.size()));
    chk("empty", 64'(sb_empty), 64'(mq.size() == 0));
    chk("full", 64'(sb_full), 64'(mq.size() == DEPTH));
    chk("overflow", 64'(sb_overflow), 64'(m_ovf));
`ifdef SB_LOAD_FWD_EN
    begin
      bit h = 1'b0, s = 1'b0;
      logic [31:0] fd = '0;
      for (int k = mq.size() - 1; k >= 0; k--) begin
        if (mq[k].addr[31:3] == ld_addr[31:3]) begin
          h  = (mq[k].addr == ld_addr) && (mq[k].size == ld_size);
          s  = !h;
          fd = h ? mq[k].data : 32'h0;
          break;
        end
      end
      smp_hit = fwd_hit; smp_stall = fwd_stall; smp_fdata = fwd_data;
      chk("fwd_hit", 64'(fwd_hit), 64'(h));
      chk("fwd_stall", 64'(fwd_stall), 64'(s));
      if (h) chk("fwd_data", 64'(fwd_data), 64'(fd));
    end
`endif
    if (proc2Dmem_command == BUS_STORE && resp != 4'h0) issued.push_back(proc2Dmem_addr);
    @(posedge clock);
    n_before = mq.size();
    if (exp_store && resp != 4'h0) void'(mq.pop_front());
    if (cmd == BUS_STORE) begin
      if (n_before == DEPTH) m_ovf = 1'b1;
      else mq.push_back('{size: sz, addr: a, data: d});
    end
    m_active = m_active ? (mq.size() != 0) : (n_before != 0);
    #1;
  endtask

  task automatic idle(input logic busy, input logic [3:0] resp);
    step(BUS_NONE, 32'h0, 32'h0, BYTE, busy, resp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    st_command = BUS_NONE; dmem_port_busy = 1'b0; Dmem2proc_response = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[13];
    // Single store latency, then three stores held off by a busy port and drained in order.
    tv[0]  = '{BUS_STORE, 32'h100, 32'hDEAD_BEEF, WORD, 1'b0, 4'h1, BUS_NONE,  32'h0,   0, 1'b1};
    tv[1]  = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b0, 4'h1, BUS_NONE,  32'h0,   1, 1'b0};
    tv[2]  = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b0, 4'h1, BUS_STORE, 32'h100, 1, 1'b0};
    tv[3]  = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b0, 4'h1, BUS_NONE,  32'h0,   0, 1'b1};
    tv[4]  = '{BUS_STORE, 32'h300, 32'h1,        WORD, 1'b1, 4'h1, BUS_NONE,  32'h0,   0, 1'b1};
    tv[5]  = '{BUS_STORE, 32'h304, 32'h2,        WORD, 1'b1, 4'h1, BUS_NONE,  32'h0,   1, 1'b0};
    tv[6]  = '{BUS_STORE, 32'h308, 32'h3,        WORD, 1'b1, 4'h1, BUS_NONE,  32'h0,   2, 1'b0};
    tv[7]  = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b1, 4'h1, BUS_NONE,  32'h0,   3, 1'b0};
    tv[8]  = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b1, 4'h1, BUS_NONE,  32'h0,   3, 1'b0};
    tv[9]  = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b0, 4'h1, BUS_STORE, 32'h300, 3, 1'b0};
    tv[10] = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b0, 4'h1, BUS_STORE, 32'h304, 2, 1'b0};
    tv[11] = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b0, 4'h1, BUS_STORE, 32'h308, 1, 1'b0};
    tv[12] = '{BUS_NONE,  32'h0,   32'h0,        BYTE, 1'b0, 4'h1, BUS_NONE,  32'h0,   0, 1'b1};

    reset_n = 1'b0;
    st_command = BUS_NONE; st_addr = '0; st_data = '0; st_size = BYTE;
    dmem_port_busy = 1'b0; Dmem2proc_response = 4'h0;
`ifdef SB_LOAD_FWD_EN
    ld_addr = '0; ld_size = BYTE;
`endif
    #12;
    chk("rst_cmd", 64'(proc2Dmem_command), 64'(BUS_NONE));
    chk("rst_empty", 64'(sb_empty), 64'h1);
    chk("rst_full", 64'(sb_full), 64'h0);
    chk("rst_count", 64'(sb_count), 64'h0);
    chk("rst_overflow", 64'(sb_overflow), 64'h0);
    @(posedge clock); #1;
    model_reset();
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tv[i].cmd, tv[i].addr, tv[i].data, tv[i].size, tv[i].busy, tv[i].resp);
      chk("tv_cmd", 64'(smp_cmd), 64'(tv[i].e_cmd));
      chk("tv_count", 64'(smp_count), 64'(tv[i].e_count));
      chk("tv_empty", 64'(smp_empty), 64'(tv[i].e_empty));
      if (tv[i].e_cmd == BUS_STORE) chk("tv_addr", 64'(smp_addr), 64'(tv[i].e_addr));
    end

    // Fill with no responses, overflow on the ninth, then drain: only the first eight appear.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(BUS_STORE, 32'h400 + 32'(4 * i), 32'(i), WORD, 1'b0, 4'h0);
    idle(1'b0, 4'h0);
    chk("fill_full", 64'(smp_full), 64'h1);
    step(BUS_STORE, 32'h4FC, 32'h99, WORD, 1'b0, 4'h0);
    idle(1'b0, 4'h0);
    chk("ninth_overflow", 64'(smp_ovf), 64'h1);
    issued.delete();
    repeat (12) idle(1'b0, 4'h3);
    chk("drain_issued", 64'(issued.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH && i < issued.size(); i++)
      chk("drain_order", 64'(issued[i]), 64'(32'h400 + 32'(4 * i)));

    // Full buffer: pop and enqueue together; the new store is still dropped.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(BUS_STORE, 32'h500 + 32'(4 * i), 32'(i), WORD, 1'b0, 4'h0);
    step(BUS_STORE, 32'h5F0, 32'h77, WORD, 1'b0, 4'h1);
    idle(1'b0, 4'h0);
    chk("popfull_count", 64'(smp_count), 64'h7);
    chk("popfull_overflow", 64'(smp_ovf), 64'h1);

    // Reset mid-drain with four queued and overflow set.
    repeat (3) idle(1'b0, 4'h1);
    idle(1'b0, 4'h0);
    #2;
    chk("middrain_pre_cmd", 64'(proc2Dmem_command), 64'(BUS_STORE));
    chk("middrain_pre_count", 64'(sb_count), 64'h4);
    reset_n = 1'b0;
    #1;
    chk("middrain_cmd", 64'(proc2Dmem_command), 64'(BUS_NONE));
    chk("middrain_count", 64'(sb_count), 64'h0);
    chk("middrain_overflow", 64'(sb_overflow), 64'h0);
    @(posedge clock); #1;
    model_reset();
    reset_n = 1'b1;

`ifdef SB_LOAD_FWD_EN
    ld_addr = 32'h200; ld_size = WORD;
    step(BUS_STORE, 32'h200, 32'h11, WORD, 1'b1, 4'h0);
    step(BUS_STORE, 32'h200, 32'h22, WORD, 1'b1, 4'h0);
    idle(1'b1, 4'h0);
    chk("fwd_exact_hit", 64'(smp_hit), 64'h1);
    chk("fwd_exact_data", 64'(smp_fdata), 64'h22);
    ld_addr = 32'h202; ld_size = HALF;
    idle(1'b1, 4'h0);
    chk("fwd_partial_stall", 64'(smp_stall), 64'h1);
    chk("fwd_partial_hit", 64'(smp_hit), 64'h0);
    do_reset();
`endif

    // Randomized traffic: a congested phase followed by a mostly-accepting phase.
    for (int c = 0; c < 400; c++) begin
      logic [1:0]  cmd;
      logic [31:0] a;
      logic [3:0]  resp;
      cmd = ($urandom_range(0, 99) < 55) ? BUS_STORE : 2'($urandom_range(0, 3));
      a = 32'h600 + 32'(8 * $urandom_range(0, 3)) + 32'(4 * $urandom_range(0, 1));
      if ($urandom_range(0, 99) < ((c < 200) ? 25 : 75)) resp = 4'($urandom_range(1, 15));
      else resp = 4'h0;
`ifdef SB_LOAD_FWD_EN
      ld_addr = 32'h600 + 32'(8 * $urandom_range(0, 3)) + 32'(2 * $urandom_range(0, 3));
      ld_size = MEM_SIZE'($urandom_range(0, 3));
`endif
      step(cmd, a, $urandom, MEM_SIZE'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), resp);
    end
    repeat (12) idle(1'b0, 4'h1);
    chk("final_empty", 64'(smp_empty), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
